axi_int2ram_top: RTL and testbench

- Integer matrix-multiply accelerator wrapper.
- Configured by a host over an AXI-Lite slave port.
- Fetches operands from, and writes results to, an external byte-addressable memory over a simple word-wide RAM port: read with 1-cycle latency, write with byte strobes.
- Computes Y = Xᵀ·K and raises a done flag in its config register bank.

---
 rtl/axi_int2ram_top.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_int2ram_top.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_int2ram_top.sv
// Integer matrix-multiply engine (Y = X^T * K) behind an AXI-Lite register bank.
// Operands and results live in an external word-wide RAM with 1-cycle read latency.
module axi_int2ram_top #(
    parameter int R                 = 4,
    parameter int C                 = 4,
    parameter int WK                = 8,
    parameter int WX                = 8,
    parameter int WA                = 32,
    parameter int WY                = 32,
    parameter int LM                = 1,
    parameter int LA                = 1,
    parameter int VALID_PROB        = 1000,
    parameter int READY_PROB        = 1000,
    parameter int AXI_WIDTH         = 128,
    parameter int AXI_ID_WIDTH      = 6,
    parameter int AXI_STRB_WIDTH    = AXI_WIDTH / 8,
    parameter int AXI_MAX_BURST_LEN = 32,
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int AXIL_WIDTH        = 32,
    parameter int AXIL_ADDR_WIDTH   = 40,
    parameter int STRB_WIDTH        = 4,
    parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR = 'hB000_0000,
    localparam int LSB              = $clog2(AXI_WIDTH) - 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIL_ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [2:0]                    s_axil_awprot,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [AXIL_WIDTH-1:0]         s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]         s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic [2:0]                    s_axil_arprot,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [AXIL_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic                          ren,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] raddr,
    input  logic [AXI_WIDTH-1:0]          rdata,
    output logic                          wen,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] waddr,
    output logic [AXI_WIDTH-1:0]          wdata,
    output logic [AXI_WIDTH/8-1:0]        wstrb
);
    localparam int NB   = AXI_WIDTH / 8;
    localparam int RW   = $clog2(R + 1);
    localparam int CW   = $clog2(C + 1);
    localparam int NREG = 8;
    localparam logic [NB-1:0] YMASK = NB'((1 << (WY / 8)) - 1);

    function automatic logic [AXIL_WIDTH-1:0] merge_bytes(input logic [AXIL_WIDTH-1:0] old,
                                                          input logic [AXIL_WIDTH-1:0] data,
                                                          input logic [STRB_WIDTH-1:0] strb);
        logic [AXIL_WIDTH-1:0] res;
        res = old;
        for (int i = 0; i < STRB_WIDTH; i++)
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        return res;
    endfunction

    function automatic logic [WY-1:0] wrap_y(input logic signed [WA-1:0] a);
        return a[WY-1:0];
    endfunction

    function automatic logic [AXI_WIDTH-1:0] lane_down(input logic [AXI_WIDTH-1:0] w,
                                                        input logic [LSB-1:0] lane);
        return w >> {lane, 3'b000};
    endfunction

    logic [AXIL_WIDTH-1:0]      cfg [NREG];
    logic [AXIL_ADDR_WIDTH-1:0] woff, roff;
    logic                       wr_hit, rd_hit, wr_en;
    logic [2:0]                 widx, ridx;
    logic [AXIL_WIDTH-1:0]      rd_val;
    logic                       start, set_done, clr_done;

    assign woff   = s_axil_awaddr - AXIL_BASE_ADDR;
    assign roff   = s_axil_araddr - AXIL_BASE_ADDR;
    assign wr_hit = (s_axil_awaddr >= AXIL_BASE_ADDR) && (woff[AXIL_ADDR_WIDTH-1:5] == '0);
    assign rd_hit = (s_axil_araddr >= AXIL_BASE_ADDR) && (roff[AXIL_ADDR_WIDTH-1:5] == '0);
    assign widx   = woff[4:2];
    assign ridx   = roff[4:2];

    assign s_axil_awready = !rst && s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid;
    assign s_axil_wready  = s_axil_awready;
    assign s_axil_arready = !rst && s_axil_arvalid && !s_axil_rvalid;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rresp   = 2'b00;
    assign wr_en          = s_axil_awready && wr_hit;
    assign start          = cfg[0][0];

    // A read colliding with a write to the same register returns the written value.
    always_comb begin
        rd_val = '0;
        if (rd_hit) begin
            rd_val = cfg[ridx];
            if (wr_en && (widx == ridx))
                rd_val = merge_bytes(cfg[ridx], s_axil_wdata, s_axil_wstrb);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) cfg[i] <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_rvalid <= 1'b0;
        end else begin
            cfg[0] <= '0;
            if (wr_en) cfg[widx] <= merge_bytes(cfg[widx], s_axil_wdata, s_axil_wstrb);
            if (set_done)      cfg[1] <= AXIL_WIDTH'(1);
            else if (clr_done) cfg[1] <= '0;
            if (s_axil_awready)     s_axil_bvalid <= 1'b1;
            else if (s_axil_bready) s_axil_bvalid <= 1'b0;
            if (s_axil_arready)     s_axil_rvalid <= 1'b1;
            else if (s_axil_rready) s_axil_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_axil_arready) s_axil_rdata <= rd_val;
    end

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_CLR, S_RDX, S_WX, S_GETX, S_RDK, S_WK, S_MAC, S_WR, S_DONE
    } state_t;

    state_t                     state, state_nxt;
    logic [RW-1:0]              r;
    logic [CW-1:0]              c;
    logic [AXIL_WIDTH-1:0]      k;
    logic signed [WX-1:0]       x_val;
    logic signed [WK-1:0]       k_val;
    logic signed [WA-1:0]       x_ext, k_ext, prod, acc;
    logic [AXI_ADDR_WIDTH-1:0]  x_byte, k_byte, y_byte;

    assign x_byte = AXI_ADDR_WIDTH'(cfg[3]) + (AXI_ADDR_WIDTH'(k) * AXI_ADDR_WIDTH'(R)
                    + AXI_ADDR_WIDTH'(r)) * AXI_ADDR_WIDTH'(WX / 8);
    assign k_byte = AXI_ADDR_WIDTH'(cfg[2]) + (AXI_ADDR_WIDTH'(k) * AXI_ADDR_WIDTH'(C)
                    + AXI_ADDR_WIDTH'(c)) * AXI_ADDR_WIDTH'(WK / 8);
    assign y_byte = AXI_ADDR_WIDTH'(cfg[4]) + (AXI_ADDR_WIDTH'(r) * AXI_ADDR_WIDTH'(C)
                    + AXI_ADDR_WIDTH'(c)) * AXI_ADDR_WIDTH'(WY / 8);

    // K is consumed straight off the RAM bus in MAC; X was latched in GETX.
    assign k_val = WK'(lane_down(rdata, k_byte[LSB-1:0]));
    assign x_ext = WA'(x_val);
    assign k_ext = WA'(k_val);
    assign prod  = x_ext * k_ext;

    assign ren   = (state == S_RDX) || (state == S_RDK);
    assign raddr = (state == S_RDK) ? k_byte[AXI_ADDR_WIDTH-1:LSB] : x_byte[AXI_ADDR_WIDTH-1:LSB];
    assign wen   = (state == S_WR);
    assign waddr = y_byte[AXI_ADDR_WIDTH-1:LSB];
    assign wdata = AXI_WIDTH'(wrap_y(acc)) << {y_byte[LSB-1:0], 3'b000};
    assign wstrb = wen ? (YMASK << y_byte[LSB-1:0]) : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        set_done  = 1'b0;
        clr_done  = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                state_nxt = S_INIT;
                clr_done  = 1'b1;
            end
            S_INIT: state_nxt = S_CLR;
            S_CLR: begin
                if (r == RW'(R))    state_nxt = S_DONE;
                else if (k == cfg[5]) state_nxt = S_WR;
                else                state_nxt = S_RDX;
            end
            S_RDX:  state_nxt = S_WX;
            S_WX:   state_nxt = S_GETX;
            S_GETX: state_nxt = S_RDK;
            S_RDK:  state_nxt = S_WK;
            S_WK:   state_nxt = S_MAC;
            S_MAC:  state_nxt = S_CLR;
            S_WR:   state_nxt = S_INIT;
            S_DONE: begin
                set_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            c <= '0;
            k <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    r <= '0;
                    c <= '0;
                end
                S_INIT: k <= '0;
                S_MAC:  k <= k + 1'b1;
                S_WR: begin
                    if (c == CW'(C - 1)) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            S_INIT: acc   <= '0;
            S_GETX: x_val <= WX'(lane_down(rdata, x_byte[LSB-1:0]));
            S_MAC:  acc   <= acc + prod;
            default: ;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, woff[1:0], roff[1:0],
                         32'(LM), 32'(LA), 32'(VALID_PROB), 32'(READY_PROB),
                         32'(AXI_ID_WIDTH), 32'(AXI_STRB_WIDTH), 32'(AXI_MAX_BURST_LEN)};
endmodule

// File: tb/tb_axi_int2ram_top.sv
// Directed bench for axi_int2ram_top: AXI-Lite register access plus full matrix runs
// against a behavioural 1-cycle RAM and a small reference product model.
`timescale 1ns/1ps
module tb_axi_int2ram_top;
    localparam logic [39:0] BASE = 40'hB000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [39:0]  s_axil_awaddr;
    logic [2:0]   s_axil_awprot;
    logic         s_axil_awvalid, s_axil_awready;
    logic [31:0]  s_axil_wdata;
    logic [3:0]   s_axil_wstrb;
    logic         s_axil_wvalid, s_axil_wready;
    logic [1:0]   s_axil_bresp;
    logic         s_axil_bvalid, s_axil_bready;
    logic [39:0]  s_axil_araddr;
    logic [2:0]   s_axil_arprot;
    logic         s_axil_arvalid, s_axil_arready;
    logic [31:0]  s_axil_rdata;
    logic [1:0]   s_axil_rresp;
    logic         s_axil_rvalid, s_axil_rready;
    logic         ren, wen;
    logic [27:0]  raddr, waddr;
    logic [127:0] rdata, wdata;
    logic [15:0]  wstrb;

    always #5 clk = ~clk;

    axi_int2ram_top dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .ren(ren), .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RAM: X/K image written only by the stimulus process, Y captured only by the monitor.
    logic [127:0] mem  [0:63];
    logic [127:0] ymem [0:3];
    logic         clr_y = 1'b0;
    int           wr_count, bad_strb, bad_addr, both_cnt;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr[5:0]];
        if (clr_y) begin
            for (int i = 0; i < 4; i++) ymem[i] <= {16{8'hEE}};
            wr_count <= 0;
            bad_strb <= 0;
            bad_addr <= 0;
            both_cnt <= 0;
        end else begin
            if (ren && wen) both_cnt <= both_cnt + 1;
            if (wen) begin
                wr_count <= wr_count + 1;
                if ($countones(wstrb) != 4) bad_strb <= bad_strb + 1;
                if (waddr[27:2] != 26'd12) bad_addr <= bad_addr + 1;
                else for (int b = 0; b < 16; b++)
                    if (wstrb[b]) ymem[waddr[1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    int xv [0:1][0:3];
    int kv [0:1][0:3];
    int kd;

    task automatic put_byte(input int a, input logic [7:0] v);
        mem[a / 16][(a % 16) * 8 +: 8] = v;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int k = 0; k < kd; k++)
            for (int j = 0; j < 4; j++) begin
                put_byte(32'h200 + k * 4 + j, 8'(xv[k][j]));
                put_byte(32'h100 + k * 4 + j, 8'(kv[k][j]));
            end
    endtask

    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] w;
        int s;
        w = '0;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int k = 0; k < kd; k++) s += xv[k][r] * kv[k][c];
            w[32*c +: 32] = s;
        end
        return w;
    endfunction

    task automatic axil_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("aw_timeout", n, 0);
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axil_bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("b_timeout", n, 0);
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
    endtask

    logic [1:0] last_rresp;
    logic [1:0] last_bresp;

    task automatic axil_read(input logic [39:0] a, output logic [31:0] d);
        int n;
        d = '0;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axil_arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("ar_timeout", n, 0);
        @(posedge clk); #1;
        s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axil_rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("r_timeout", n, 0);
        d = s_axil_rdata;
        last_rresp = s_axil_rresp;
        @(posedge clk); #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic clear_y();
        clr_y = 1'b1;
        @(posedge clk); #1;
        clr_y = 1'b0;
    endtask

    task automatic start_run();
        load_mem();
        clear_y();
        axil_write(BASE + 40'h08, 32'h100, 4'hF);
        axil_write(BASE + 40'h0C, 32'h200, 4'hF);
        axil_write(BASE + 40'h10, 32'h300, 4'hF);
        axil_write(BASE + 40'h14, 32'(kd), 4'hF);
        axil_write(BASE + 40'h00, 32'h1, 4'hF);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        int n;
        d = '0;
        n = 0;
        while (!d[0] && n < 150) begin axil_read(BASE + 40'h04, d); n++; end
        check(tag, d, 32'h1);
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) check($sformatf("%s_row%0d", tag, i), ymem[i], exp_row(i));
        check({tag, "_wcount"}, wr_count, 16);
        check({tag, "_strb"}, bad_strb, 0);
        check({tag, "_addr"}, bad_addr, 0);
    endtask

    task automatic set_signed_data();
        kd = 2;
        xv[0] = '{-3, 4, -128, 127};
        xv[1] = '{2, -5, 1, 127};
        kv[0] = '{5, -1, 2, 127};
        kv[1] = '{-1, 3, -128, -128};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int wc;
        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        last_rresp = 2'b11;
        last_bresp = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ren", ren, 0);
        check("rst_wen", wen, 0);
        check("rst_bvalid", s_axil_bvalid, 0);
        check("rst_rvalid", s_axil_rvalid, 0);
        check("rst_bresp", s_axil_bresp, 0);
        check("rst_rresp", s_axil_rresp, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            axil_read(BASE + 40'(i * 4), d);
            check($sformatf("rst_cfg%0d", i), d, 0);
        end
        check("rresp_okay", last_rresp, 0);

        // Byte-strobed scratch write and out-of-range read.
        s_axil_bready = 1'b0;
        axil_write(BASE + 40'h18, 32'hA5A5_A5A5, 4'b0011);
        axil_read(BASE + 40'h18, d);
        check("cfg6_strb", d, 32'h0000_A5A5);
        axil_read(BASE + 40'h40, d);
        check("oor_read", d, 0);
        check("oor_rresp", last_rresp, 0);

        // KDIM = 1: Y[r][c] = r + 1.
        kd = 1;
        xv[0] = '{1, 2, 3, 4};
        kv[0] = '{1, 1, 1, 1};
        start_run();
        wait_done("run1_done");
        for (int i = 0; i < 4; i++) check($sformatf("run1_row%0d", i), ymem[i], {4{32'(i + 1)}});
        check("run1_wcount", wr_count, 16);
        check("run1_strb", bad_strb, 0);

        // Signed operands, KDIM = 2.
        set_signed_data();
        start_run();
        wait_done("sgn_done");
        check("sgn_y00", ymem[0][31:0], 32'hFFFF_FFEF);
        check("sgn_y33", ymem[3][127:96], 32'hFFFF_FF81);
        check_model("sgn");

        // KDIM = 0 with a second START while busy.
        kd = 0;
        start_run();
        axil_read(BASE + 40'h04, d);
        check("k0_done_cleared", d, 0);
        axil_write(BASE + 40'h00, 32'h1, 4'hF);
        wait_done("k0_done");
        repeat (60) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("k0_row%0d", i), ymem[i], 128'h0);
        check("k0_wcount", wr_count, 16);
        check("k0_addr", bad_addr, 0);

        // Reset in the middle of a run, then a clean rerun.
        set_signed_data();
        start_run();
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ren", ren, 0);
        check("midrst_wen", wen, 0);
        wc = wr_count;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_quiet", wr_count, wc);
        axil_read(BASE + 40'h04, d);
        check("midrst_done", d, 0);
        axil_read(BASE + 40'h08, d);
        check("midrst_kbase", d, 0);
        start_run();
        wait_done("rerun_done");
        check_model("rerun");
        check("ren_wen_excl", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
